uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for 8N1 serial frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receiving end of the `uart_tx` link and uses the same bit timing, 50 MHz clock and 9600 baud. It samples each bit at its midpoint and outputs each completed byte with a one-cycle strobe. It sits between the asynchronous `rx` pin and byte-level consumer logic.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: serial bit rate.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD_RATE (5208): clock cycles per bit. Derived with integer division.
- `clk`  in  1  system clock. The block has one clock domain and uses rising edges only.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input. It is asynchronous to `clk` and idles high.
- `data_out`  out  8  last correctly received byte. It holds its value until the next good frame.
- `rx_done`  out  1  one-cycle pulse when a frame completes with a valid stop bit.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high while the FSM is outside IDLE.

## Operation
- `rx` passes through a two-flop synchronizer. Both flops reset to 1, the idle line level. A third flop holds the previous synchronized value for edge detection.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3. DATA uses the same code as the transmitter's data state.
- IDLE: `bit_cnt` and `clk_cnt` are 0. A synchronized falling edge (prev=1, cur=0) moves the FSM to START. A level-low line without an edge does not trigger a frame, so a line break cannot retrigger reception.
- START: count to CLKS_PER_BIT/2 − 1 (2603), then sample the line.
  - Low: clear `clk_cnt` and go to DATA.
  - High: treat as a glitch and return to IDLE with no output.
- DATA: every CLKS_PER_BIT cycles, shift the sampled bit into the MSB of the shift register (`shift <= {rx_s, shift[7:1]}`) and increment `bit_cnt`. After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample the line.
  - High: `data_out <= shift` and pulse `rx_done`.
  - Low: pulse `frame_error` and leave `data_out` unchanged.
  - In both cases, return to IDLE.
- After the stop sample the FSM is back in IDLE while the stop bit is still on the line. This allows back-to-back frames with a single stop bit.
- `rx_done` and `frame_error` are never high in the same cycle.
- Counter widths: `clk_cnt` is $clog2(CLKS_PER_BIT) bits; `bit_cnt` is 3 bits plus a terminal compare.

## Timing
- Reset values: `data_out`=8'h00, `rx_done`=0, `frame_error`=0, `busy`=0. The FSM resets to IDLE, all counters to 0 and the synchronizer flops to 1.
- Asserting reset in mid-frame aborts the frame immediately, and no pulse is produced. After release, reception restarts at the next falling edge.
- The falling edge is detected 2 cycles after the `rx` transition, because of synchronizer latency.
- Sampling points, measured from the edge-detect cycle:
  - start bit at cycle CLKS_PER_BIT/2;
  - data bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `rx_done` or `frame_error` is registered and asserts in the cycle after the stop sample. `data_out` is valid in the same cycle as `rx_done`.
- `busy` rises in the cycle after the edge is detected and falls together with the `rx_done`/`frame_error` pulse.
- Tolerance: the receiver must accept transmitter baud error up to ±2%.

## Structure
- `uart_pkg` (shared with `uart_tx`):
  - state encoding constants;
  - default CLK_FREQ and BAUD_RATE;
  - the CLKS_PER_BIT derivation.
- Sub-module `sync_2ff`:
  - generic two-flop synchronizer with a reset-value parameter;
  - reused for other asynchronous inputs.
- The FSM, counters and shift register live in `uart_rx`. Expected size is about 150 lines.

## Test plan
- Loopback from `uart_tx`, data 8'hA5: exactly one `rx_done` pulse, `data_out`=8'hA5, `frame_error` never high.
- Sweep all 256 values through back-to-back `uart_tx` frames: every `data_out` matches, one `rx_done` per frame, no frame is dropped.
- Drive a 1000-cycle low glitch on `rx` (shorter than half a bit): FSM returns to IDLE, no `rx_done`, no `frame_error`, `data_out` unchanged.
- Hand-driven frame 8'h3C with the stop bit forced low: `frame_error` pulses once, `data_out` keeps its previous value, `rx_done` stays 0. A following good frame 8'h81 is received correctly.
- Assert reset for 20 cycles mid-way through the data bits: all outputs read reset values, no pulse appears. The next full frame 8'h5A is received correctly.
- Frame sent at BAUD_RATE·1.02 and at BAUD_RATE·0.98, data 8'hFF and 8'h00: both are received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx / uart_rx pair: FSM state codes,
// default link timing and the cycles-per-bit derivation.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;

  // Integer division: any fractional remainder becomes baud error on the link.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte/status out.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_error;
  logic       busy;

  modport master (
    input  rx,
    output data_out,
    output rx_done,
    output frame_error,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  rx_done,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value
// is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge, samples each
// bit at its midpoint and emits the byte with a one-cycle rx_done strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE    = DEF_BAUD_RATE,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  logic             rx_prev_q,  rx_prev_d;
  uart_state_e      state_q,    state_d;
  logic [CNT_W-1:0] clk_cnt_q,  clk_cnt_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [7:0]       shift_q,    shift_d;
  logic [7:0]       data_q,     data_d;
  logic             done_q,     done_d;
  logic             ferr_q,     ferr_d;
  logic             busy_q,     busy_d;
  logic             fall_edge;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Only a high-to-low transition starts a frame; a held-low line (break) does not.
  assign fall_edge = rx_prev_q & ~rx_s;

  always_comb begin
    rx_prev_d = rx_s;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (fall_edge) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            // Line already back high at mid start bit: glitch, drop it silently.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.rx_done     = done_q;
  assign bus.frame_error = ferr_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: drives 8N1 frames on rx from a behavioural
// line driver and compares received bytes with an expected-byte queue.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int CLK_T    = 100;
  localparam int BIT_T    = CPB * CLK_T;
  localparam int BIT_FAST = (BIT_T * 100) / 102;
  localparam int BIT_SLOW = (BIT_T * 100) / 98;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #(CLK_T / 2) clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int          done_cnt = 0;
  int          ferr_cnt = 0;
  int unsigned last_done_cyc = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_done || bus.frame_error) begin
      check_eq("pulse_exclusive", 32'(bus.rx_done & bus.frame_error), 32'd0);
      check_eq("busy_low_with_pulse", 32'(bus.busy), 32'd0);
    end
    if (bus.rx_done) begin
      got_q.push_back(bus.data_out);
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.frame_error) ferr_cnt++;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_t);
    bus.rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      #(bit_t);
    end
    bus.rx = stop_bit;
    #(bit_t);
    bus.rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d, input int bit_t);
    exp_q.push_back(d);
    exp_data = d;
    send_frame(d, 1'b1, bit_t);
  endtask

  task automatic verify(input string tag);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic idle(input int n_clk);
    #(n_clk * CLK_T);
  endtask

  initial begin
    logic [7:0] vals[256];
    int          d0, f0, start_cyc;
    logic [7:0]  tmp;

    bus.rx   = 1'b1;
    exp_data = 8'h00;
    idle(5);
    check_eq("rst_data_out", 32'(bus.data_out), 32'h00);
    check_eq("rst_rx_done", 32'(bus.rx_done), 32'd0);
    check_eq("rst_frame_error", 32'(bus.frame_error), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    // single frame plus end-to-end latency
    @(negedge clk);
    start_cyc = cyc;
    send_good(8'hA5, BIT_T);
    idle(10);
    verify("a5");
    check_eq("a5_latency", 32'(last_done_cyc - start_cyc), 32'(CPB / 2 + 9 * CPB + 3));
    check_eq("a5_no_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("a5_data_out", 32'(bus.data_out), 32'hA5);

    // all 256 values, shuffled, back to back
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = $urandom_range(i, 0);
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) send_good(vals[i], BIT_T);
    idle(2 * CPB);
    verify("sweep");
    check_eq("sweep_no_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("sweep_data_out", 32'(bus.data_out), 32'(exp_data));

    // short low glitch
    d0 = done_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    idle(CPB / 4);
    bus.rx = 1'b1;
    idle(1);
    check_eq("glitch_busy_seen", 32'(bus.busy), 32'd1);
    idle(3 * CPB);
    check_eq("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check_eq("glitch_data_kept", 32'(bus.data_out), 32'(exp_data));
    check_eq("glitch_busy_idle", 32'(bus.busy), 32'd0);

    // bad stop bit, then a good frame
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BIT_T);
    idle(2 * CPB);
    check_eq("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check_eq("ferr_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("ferr_data_kept", 32'(bus.data_out), 32'(exp_data));
    send_good(8'h81, BIT_T);
    idle(2 * CPB);
    verify("after_ferr");
    check_eq("after_ferr_ferr", 32'(ferr_cnt - f0), 32'd1);

    // reset in the middle of the data bits
    d0 = done_cnt; f0 = ferr_cnt;
    tmp = 8'h5A;
    bus.rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      bus.rx = tmp[i];
      #(BIT_T);
    end
    reset  = 1'b0;
    bus.rx = 1'b1;
    exp_data = 8'h00;
    idle(20);
    check_eq("midrst_data_out", 32'(bus.data_out), 32'h00);
    check_eq("midrst_rx_done", 32'(bus.rx_done), 32'd0);
    check_eq("midrst_ferr", 32'(bus.frame_error), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    idle(3 * CPB);
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    send_good(8'h5A, BIT_T);
    idle(2 * CPB);
    verify("after_rst");
    check_eq("after_rst_data_out", 32'(bus.data_out), 32'h5A);

    // transmitter baud error of +2% and -2%
    f0 = ferr_cnt;
    send_good(8'hFF, BIT_FAST); idle(2 * CPB);
    send_good(8'h00, BIT_FAST); idle(2 * CPB);
    send_good(8'($urandom_range(255, 0)), BIT_FAST); idle(2 * CPB);
    send_good(8'hFF, BIT_SLOW); idle(2 * CPB);
    send_good(8'h00, BIT_SLOW); idle(2 * CPB);
    send_good(8'($urandom_range(255, 0)), BIT_SLOW); idle(2 * CPB);
    verify("baud");
    check_eq("baud_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check_eq("final_data_out", 32'(bus.data_out), 32'(exp_data));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
